// File: rtl/m1_state_regfile_mc_if.sv
// Bundle between the SHA-2 round datapath and the multi-channel working-state register file.
// Carries load/round/abort requests, the registered read port and the digest/error pulses.
// Only load uses a handshake (load_ready); rounds and aborts are fire-and-forget.
interface m1_state_regfile_mc_if #(
    parameter int WORD_W = 32,
    parameter int NUM_CH = 2,
    parameter int ROUNDS = 64
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(ROUNDS);

    logic                  clk_h_en;
    logic                  load_valid;
    logic [CH_W-1:0]       load_ch;
    logic [8*WORD_W-1:0]   load_data;
    logic                  load_ready;
    logic                  rnd_valid;
    logic [CH_W-1:0]       rnd_ch;
    logic [WORD_W-1:0]     rnd_a_in;
    logic [WORD_W-1:0]     rnd_e_in;
    logic                  abort_valid;
    logic [CH_W-1:0]       abort_ch;
    logic [CH_W-1:0]       rd_ch;
    logic [WORD_W-1:0]     a, b, c, d, e, f, g, h;
    logic [CNT_W-1:0]      rd_cnt;
    logic [NUM_CH-1:0]     busy;
    logic                  done_valid;
    logic [CH_W-1:0]       done_ch;
    logic [8*WORD_W-1:0]   done_data;
    logic                  rnd_err;

    modport master (
        output clk_h_en, load_valid, load_ch, load_data, rnd_valid, rnd_ch, rnd_a_in, rnd_e_in,
               abort_valid, abort_ch, rd_ch,
        input  load_ready, a, b, c, d, e, f, g, h, rd_cnt, busy, done_valid, done_ch, done_data, rnd_err
    );

    modport slave (
        input  clk_h_en, load_valid, load_ch, load_data, rnd_valid, rnd_ch, rnd_a_in, rnd_e_in,
               abort_valid, abort_ch, rd_ch,
        output load_ready, a, b, c, d, e, f, g, h, rd_cnt, busy, done_valid, done_ch, done_data, rnd_err
    );
endinterface

// File: rtl/m1_state_regfile_mc.sv
// Multi-channel SHA-2 a..h working-state file with per-channel IV copy, round counter and digest feed-forward.
// Latency: read port and digest/error pulses are 1 cycle after the accepting edge (read port is write-through).
// Backpressure: load stalls via load_ready while the channel runs; clk_h_en=0 freezes everything.
module m1_state_regfile_mc #(
    parameter int WORD_W = 32,
    parameter int NUM_CH = 2,
    parameter int ROUNDS = 64
) (
    input  logic                 clk_h,
    input  logic                 rst_n,
    m1_state_regfile_mc_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(ROUNDS);
    localparam int DW    = 8 * WORD_W;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} ch_state_t;

    ch_state_t         r_fsm [NUM_CH];
    logic [DW-1:0]     r_st  [NUM_CH];
    logic [DW-1:0]     r_iv  [NUM_CH];
    logic [CNT_W-1:0]  r_cnt [NUM_CH];

    ch_state_t         w_fsm_nxt [NUM_CH];
    logic [DW-1:0]     w_st_nxt  [NUM_CH];
    logic [DW-1:0]     w_iv_nxt  [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];

    logic [DW-1:0]     w_sel_st, w_sel_iv, w_shift, w_digest;
    logic              w_rnd_hit, w_rnd_err, w_load_ready, w_fin_any;
    logic [CH_W-1:0]   w_fin_ch;
    logic [DW-1:0]     w_rd_st;
    logic [CNT_W-1:0]  w_rd_cnt;
    logic [NUM_CH-1:0] w_busy;

    logic [DW-1:0]     r_rd_st;
    logic [CNT_W-1:0]  r_rd_cnt;
    logic              r_done_valid, r_rnd_err;
    logic [CH_W-1:0]   r_done_ch;
    logic [DW-1:0]     r_done_data;

    // Select the round channel's state/IV and build the shifted state plus its feed-forward digest.
    always_comb begin
        w_sel_st     = '0;
        w_sel_iv     = '0;
        w_rnd_hit    = 1'b0;
        w_load_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rnd_ch == CH_W'(i)) begin
                w_sel_st  = r_st[i];
                w_sel_iv  = r_iv[i];
                w_rnd_hit = (r_fsm[i] == ST_RUN);
            end
            if (bus.load_ch == CH_W'(i)) begin
                w_load_ready = bus.clk_h_en & (r_fsm[i] == ST_IDLE);
            end
        end
        w_shift[0*WORD_W +: WORD_W] = bus.rnd_a_in;
        w_shift[1*WORD_W +: WORD_W] = w_sel_st[0*WORD_W +: WORD_W];
        w_shift[2*WORD_W +: WORD_W] = w_sel_st[1*WORD_W +: WORD_W];
        w_shift[3*WORD_W +: WORD_W] = w_sel_st[2*WORD_W +: WORD_W];
        w_shift[4*WORD_W +: WORD_W] = bus.rnd_e_in;
        w_shift[5*WORD_W +: WORD_W] = w_sel_st[4*WORD_W +: WORD_W];
        w_shift[6*WORD_W +: WORD_W] = w_sel_st[5*WORD_W +: WORD_W];
        w_shift[7*WORD_W +: WORD_W] = w_sel_st[6*WORD_W +: WORD_W];
        for (int j = 0; j < 8; j++) begin
            w_digest[j*WORD_W +: WORD_W] = w_shift[j*WORD_W +: WORD_W] + w_sel_iv[j*WORD_W +: WORD_W];
        end
        // Out-of-range or non-running target: the round is dropped and flagged.
        w_rnd_err = bus.clk_h_en & bus.rnd_valid & ~w_rnd_hit;
    end

    // Per-channel next state: abort beats round; load only lands on an idle channel.
    always_comb begin
        w_fin_any = 1'b0;
        w_fin_ch  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_fsm_nxt[i] = r_fsm[i];
            w_st_nxt[i]  = r_st[i];
            w_iv_nxt[i]  = r_iv[i];
            w_cnt_nxt[i] = r_cnt[i];
            if (bus.clk_h_en && r_fsm[i] == ST_RUN && bus.abort_valid && bus.abort_ch == CH_W'(i)) begin
                w_fsm_nxt[i] = ST_IDLE;
            end else if (bus.clk_h_en && r_fsm[i] == ST_RUN && bus.rnd_valid && bus.rnd_ch == CH_W'(i)) begin
                w_st_nxt[i] = w_shift;
                if (r_cnt[i] == CNT_W'(ROUNDS - 1)) begin
                    w_cnt_nxt[i] = '0;
                    w_fsm_nxt[i] = ST_IDLE;
                    w_fin_any    = 1'b1;
                    w_fin_ch     = CH_W'(i);
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end else if (bus.clk_h_en && r_fsm[i] == ST_IDLE && bus.load_valid && bus.load_ch == CH_W'(i)) begin
                w_st_nxt[i]  = bus.load_data;
                w_iv_nxt[i]  = bus.load_data;
                w_cnt_nxt[i] = '0;
                w_fsm_nxt[i] = ST_RUN;
            end
        end
    end

    // Read-port mux taps the next-state values so a same-edge write is visible immediately.
    always_comb begin
        w_rd_st  = '0;
        w_rd_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_busy[i] = (r_fsm[i] == ST_RUN);
            if (bus.rd_ch == CH_W'(i)) begin
                w_rd_st  = w_st_nxt[i];
                w_rd_cnt = w_cnt_nxt[i];
            end
        end
    end

    // Channel storage and FSMs; next-state already equals current state when disabled.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_fsm[i] <= ST_IDLE;
                r_st[i]  <= '0;
                r_iv[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_fsm[i] <= w_fsm_nxt[i];
                r_st[i]  <= w_st_nxt[i];
                r_iv[i]  <= w_iv_nxt[i];
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // Registered read port, digest pulse (data held until next digest) and round-error pulse.
    always_ff @(posedge clk_h or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_st      <= '0;
            r_rd_cnt     <= '0;
            r_done_valid <= 1'b0;
            r_done_ch    <= '0;
            r_done_data  <= '0;
            r_rnd_err    <= 1'b0;
        end else begin
            r_done_valid <= w_fin_any;
            r_rnd_err    <= w_rnd_err;
            if (w_fin_any) begin
                r_done_ch   <= w_fin_ch;
                r_done_data <= w_digest;
            end
            if (bus.clk_h_en) begin
                r_rd_st  <= w_rd_st;
                r_rd_cnt <= w_rd_cnt;
            end
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.busy       = w_busy;
    assign bus.done_valid = r_done_valid;
    assign bus.done_ch    = r_done_ch;
    assign bus.done_data  = r_done_data;
    assign bus.rnd_err    = r_rnd_err;
    assign bus.rd_cnt     = r_rd_cnt;
    assign bus.a          = r_rd_st[0*WORD_W +: WORD_W];
    assign bus.b          = r_rd_st[1*WORD_W +: WORD_W];
    assign bus.c          = r_rd_st[2*WORD_W +: WORD_W];
    assign bus.d          = r_rd_st[3*WORD_W +: WORD_W];
    assign bus.e          = r_rd_st[4*WORD_W +: WORD_W];
    assign bus.f          = r_rd_st[5*WORD_W +: WORD_W];
    assign bus.g          = r_rd_st[6*WORD_W +: WORD_W];
    assign bus.h          = r_rd_st[7*WORD_W +: WORD_W];
endmodule

// File: tb/tb_m1_state_regfile_mc.sv
// Bench for the multi-channel SHA-2 state file: directed loads/rounds/aborts with hand-derived digests.
// Digests are queued when the final round is issued and checked by an independent monitor on done_valid.
// Inline checks cover reset, read port, busy, load_ready, rnd_err, enable hold and mid-run reset.
module tb_m1_state_regfile_mc;
    typedef logic [255:0] dw_t;
    typedef struct {
        logic ch;
        dw_t  data;
    } done_t;

    logic clk_h = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_h = ~clk_h;

    m1_state_regfile_mc_if #(.WORD_W(32), .NUM_CH(2), .ROUNDS(64)) bus ();

    m1_state_regfile_mc #(.WORD_W(32), .NUM_CH(2), .ROUNDS(64)) u_dut (
        .clk_h (clk_h),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    total = 0;
    int    bad   = 0;
    done_t exp_q[$];
    int    err_exp = 0;

    localparam dw_t SHA_IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                              32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
    localparam dw_t DIG_T2 = {32'h5be0cd1b, 32'h1f83d9ad, 32'h9b05688e, 32'h510e5281,
                              32'ha54ff53b, 32'h3c6ef373, 32'hbb67ae86, 32'h6a09e668};
    localparam dw_t L1     = {32'h08080808, 32'h07070707, 32'h06060606, 32'h05050505,
                              32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101};
    localparam dw_t L2     = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                              32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    task automatic chk(input string name, input dw_t act, input dw_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] a_in_of(input int c, input int k);
        return 32'ha0000000 + 32'(c << 16) + 32'(k);
    endfunction

    function automatic logic [31:0] e_in_of(input int c, input int k);
        return 32'he0000000 + 32'(c << 16) + 32'(k);
    endfunction

    // After 64 rounds a..d are the last four a_in values (newest in a), e..h the last four e_in values.
    function automatic dw_t exp_digest(input dw_t iv, input int c);
        dw_t r;
        for (int j = 0; j < 4; j++) begin
            r[j*32 +: 32]     = iv[j*32 +: 32] + a_in_of(c, 63 - j);
            r[(j+4)*32 +: 32] = iv[(j+4)*32 +: 32] + e_in_of(c, 63 - j);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk_h);
        #1;
    endtask

    task automatic do_load(input logic ch, input dw_t data);
        bus.load_valid = 1'b1;
        bus.load_ch    = ch;
        bus.load_data  = data;
        #1;
        chk("load_ready_idle", 256'(bus.load_ready), 256'(1));
        step();
        bus.load_valid = 1'b0;
    endtask

    task automatic do_round(input logic ch, input logic [31:0] ai, input logic [31:0] ei);
        bus.rnd_valid = 1'b1;
        bus.rnd_ch    = ch;
        bus.rnd_a_in  = ai;
        bus.rnd_e_in  = ei;
        step();
        bus.rnd_valid = 1'b0;
    endtask

    // Monitor: every digest pulse must match the head of the expected queue; stray error pulses are flagged.
    always @(negedge clk_h) begin
        if (bus.done_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected: got ch=%0d data=%h want no digest", bus.done_ch, bus.done_data);
            end else begin
                done_t e;
                e = exp_q.pop_front();
                chk("done_ch", 256'(bus.done_ch), 256'(e.ch));
                chk("done_data", bus.done_data, e.data);
            end
        end
        if (bus.rnd_err) begin
            if (err_exp == 0) begin
                total++;
                bad++;
                $display("FAIL rnd_err_unexpected: got 1 want 0");
            end else begin
                err_exp--;
            end
        end
    end

    initial begin
        bus.clk_h_en    = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_ch     = 1'b0;
        bus.load_data   = '0;
        bus.rnd_valid   = 1'b0;
        bus.rnd_ch      = 1'b0;
        bus.rnd_a_in    = '0;
        bus.rnd_e_in    = '0;
        bus.abort_valid = 1'b0;
        bus.abort_ch    = 1'b0;
        bus.rd_ch       = 1'b0;
        repeat (2) step();

        // Reset state
        chk("rst_a", 256'(bus.a), 256'(0));
        chk("rst_h", 256'(bus.h), 256'(0));
        chk("rst_cnt", 256'(bus.rd_cnt), 256'(0));
        chk("rst_busy", 256'(bus.busy), 256'(0));
        chk("rst_done", 256'(bus.done_valid), 256'(0));
        rst_n        = 1'b1;
        bus.clk_h_en = 1'b1;
        step();

        // 1: load ch0 with the SHA-256 IV, read it back through the write-through port
        do_load(1'b0, SHA_IV);
        chk("t1_busy", 256'(bus.busy), 256'(2'b01));
        chk("t1_a", 256'(bus.a), 256'(32'h6a09e667));
        chk("t1_h", 256'(bus.h), 256'(32'h5be0cd19));

        // 2: 64 constant rounds on ch0
        exp_q.push_back('{ch: 1'b0, data: DIG_T2});
        for (int k = 0; k < 64; k++) begin
            if (k == 10) chk("t2_cnt_mid", 256'(bus.rd_cnt), 256'(10));
            do_round(1'b0, 32'h00000001, 32'h00000002);
        end
        bus.load_ch = 1'b0;
        #1;
        chk("t2_done_vld", 256'(bus.done_valid), 256'(1));
        chk("t2_word_a", 256'(bus.done_data[31:0]), 256'(32'h6a09e668));
        chk("t2_ready_after", 256'(bus.load_ready), 256'(1));
        chk("t2_busy", 256'(bus.busy), 256'(0));
        chk("t2_cnt", 256'(bus.rd_cnt), 256'(0));

        // 3: interleave ch0/ch1 rounds, ch1 finishes last
        do_load(1'b0, SHA_IV);
        do_load(1'b1, L1);
        chk("t3_busy", 256'(bus.busy), 256'(2'b11));
        exp_q.push_back('{ch: 1'b0, data: exp_digest(SHA_IV, 0)});
        exp_q.push_back('{ch: 1'b1, data: exp_digest(L1, 1)});
        for (int k = 0; k < 64; k++) begin
            do_round(1'b0, a_in_of(0, k), e_in_of(0, k));
            do_round(1'b1, a_in_of(1, k), e_in_of(1, k));
        end
        step();
        chk("t3_busy_end", 256'(bus.busy), 256'(0));
        chk("t3_held_ch", 256'(bus.done_ch), 256'(1));

        // 4: round to idle ch1 -> error, storage unchanged; load to running ch0 refused
        bus.rd_ch = 1'b1;
        err_exp++;
        do_round(1'b1, 32'hdeadbeef, 32'hcafef00d);
        chk("t4_rnd_err", 256'(bus.rnd_err), 256'(1));
        chk("t4_ch1_a", 256'(bus.a), 256'(a_in_of(1, 63)));
        chk("t4_ch1_h", 256'(bus.h), 256'(e_in_of(1, 60)));
        do_load(1'b0, L2);
        bus.load_valid = 1'b1;
        bus.load_ch    = 1'b0;
        bus.load_data  = L1;
        #1;
        chk("t4_ready_run", 256'(bus.load_ready), 256'(0));
        bus.rd_ch = 1'b0;
        step();
        bus.load_valid = 1'b0;
        chk("t4_no_reload", 256'(bus.a), 256'(32'h11111111));

        // 5: abort and round together at cnt=10
        for (int k = 0; k < 10; k++) do_round(1'b0, 32'h100 + 32'(k), 32'h200 + 32'(k));
        bus.abort_valid = 1'b1;
        bus.abort_ch    = 1'b0;
        do_round(1'b0, 32'h0badf00d, 32'h0badf00d);
        bus.abort_valid = 1'b0;
        chk("t5_busy", 256'(bus.busy), 256'(0));
        chk("t5_cnt", 256'(bus.rd_cnt), 256'(10));
        chk("t5_a", 256'(bus.a), 256'(32'h109));
        repeat (2) step();

        // 6: enable low mid-run holds everything, then asynchronous reset mid-run
        do_load(1'b0, SHA_IV);
        for (int k = 0; k < 3; k++) do_round(1'b0, 32'h7, 32'h8);
        bus.clk_h_en   = 1'b0;
        bus.rnd_valid  = 1'b1;
        bus.rnd_ch     = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_ch    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t6_ready_dis", 256'(bus.load_ready), 256'(0));
            step();
        end
        bus.rnd_valid  = 1'b0;
        bus.load_valid = 1'b0;
        chk("t6_cnt_hold", 256'(bus.rd_cnt), 256'(3));
        chk("t6_busy_hold", 256'(bus.busy), 256'(2'b01));
        bus.clk_h_en = 1'b1;
        for (int k = 0; k < 2; k++) do_round(1'b0, 32'h9, 32'ha);
        chk("t6_cnt_resume", 256'(bus.rd_cnt), 256'(5));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 256'(bus.busy), 256'(0));
        chk("t6_rst_a", 256'(bus.a), 256'(0));
        chk("t6_rst_cnt", 256'(bus.rd_cnt), 256'(0));
        chk("t6_rst_done", 256'(bus.done_data), 256'(0));
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("t6_busy_after", 256'(bus.busy), 256'(0));

        chk("digest_queue_empty", 256'(exp_q.size()), 256'(0));
        chk("rnd_err_all_seen", 256'(err_exp), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
